// File: rtl/par_sink_to_memory_pkg.sv
// Shared definitions for the parallel sink: flit geometry, counter width,
// the control-state encoding and a saturating counter helper.
package par_sink_to_memory_pkg;

    localparam int PAYLOAD_SIZE = 8;
    localparam int ADDR_BITS    = 4;
    localparam int NUM_NODES    = 16;
    localparam int RX_CNT_BITS  = 16;
    localparam int FLIT_BITS    = PAYLOAD_SIZE + ADDR_BITS;

    // The destination occupies the low bits of a flit and the payload sits above it.
    typedef struct packed {
        logic [PAYLOAD_SIZE-1:0] payload;
        logic [ADDR_BITS-1:0]    dest;
    } flit_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } sink_state_t;

    typedef logic [RX_CNT_BITS-1:0] rx_cnt_t;

    function automatic rx_cnt_t sat_inc(input rx_cnt_t value);
        return (value == '1) ? value : rx_cnt_t'(value + 1'b1);
    endfunction

endpackage

// File: rtl/par_sink_to_memory_sink_fifo.sv
// Small show-ahead FIFO for the sink. The pointers carry one extra wrap bit,
// so full and empty can be told apart without keeping a separate count.
module sink_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [width-1:0] mem [depth];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; resetting the pointers empties the FIFO,
    // and the empty mask below keeps stale entries off rd_data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/par_sink_to_memory.sv
// Ejection-port sink: checks flit destinations against this node's id, queues
// matching payloads for the local consumer and flags a complete message.
module par_sink_to_memory
    import par_sink_to_memory_pkg::*;
#(
    parameter int id       = -1,
    parameter int depth    = 4,
    parameter int msg_size = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FLIT_BITS-1:0]    item_in,
    input  logic                    valid,
    output logic                    busy,
    input  logic                    rd_en,
    output logic [PAYLOAD_SIZE-1:0] rd_data,
    output logic                    rd_valid,
    output logic [RX_CNT_BITS-1:0]  rx_count,
    output logic [RX_CNT_BITS-1:0]  misroute_count,
    output logic                    done
);

    // An id outside the address range (the default -1) never matches any flit.
    localparam bit                   ID_VALID = (id >= 0) && (id < (1 << ADDR_BITS));
    localparam logic [ADDR_BITS-1:0] ID_ADDR  = ADDR_BITS'(id);
    localparam rx_cnt_t              MSG_LAST = rx_cnt_t'(msg_size - 1);

    flit_t       flit;
    sink_state_t state;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        dest_match;
    logic        accept_match;
    logic        accept_miss;

    always_comb begin
        // NOTE: every signal gets its default first, so no branch leaves one
        // unassigned and no latch is inferred.
        flit         = flit_t'(item_in);
        dest_match   = 1'b0;
        accept       = 1'b0;
        accept_match = 1'b0;
        accept_miss  = 1'b0;
        if (ID_VALID && (flit.dest == ID_ADDR)) begin
            dest_match = 1'b1;
        end
        // busy depends only on registered occupancy, so a misrouted flit also waits.
        if (valid && !fifo_full) begin
            accept       = 1'b1;
            accept_match = dest_match;
            accept_miss  = !dest_match;
        end
    end

    sink_fifo #(
        .width (PAYLOAD_SIZE),
        .depth (depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept_match),
        .push_data (flit.payload),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy     = fifo_full;
    assign rd_valid = !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count       <= '0;
            misroute_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // update reads the value from before this edge.
            if (accept_match) begin
                rx_count <= sat_inc(rx_count);
            end
            if (accept_miss) begin
                misroute_count <= sat_inc(misroute_count);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept_match && (rx_count == MSG_LAST)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_sink_to_memory.sv
// Scoreboard bench for par_sink_to_memory: the driver keeps a queue-based
// model of the sink and a separate monitor checks every payload the consumer pops.
module tb_par_sink_to_memory;
    import par_sink_to_memory_pkg::*;

    localparam int ID    = 3;
    localparam int DEPTH = 4;
    localparam int MSG   = 12;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [FLIT_BITS-1:0]    item_in;
    logic                    valid;
    logic                    busy;
    logic                    rd_en;
    logic [PAYLOAD_SIZE-1:0] rd_data;
    logic                    rd_valid;
    logic [RX_CNT_BITS-1:0]  rx_count;
    logic [RX_CNT_BITS-1:0]  misroute_count;
    logic                    done;

    par_sink_to_memory #(.id(ID), .depth(DEPTH), .msg_size(MSG)) dut (
        .clk            (clk),
        .reset          (reset),
        .item_in        (item_in),
        .valid          (valid),
        .busy           (busy),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rx_count       (rx_count),
        .misroute_count (misroute_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected payloads in arrival order plus plain counters.
    logic [7:0] exp_q[$];
    int         occ;
    int         rx_m;
    int         mis_m;
    bit         done_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("rd_valid", rd_valid, (occ > 0));
        check("busy", busy, (occ == DEPTH));
        check("rx_count", rx_count, rx_m);
        check("misroute_count", misroute_count, mis_m);
        check("done", done, done_m);
        if (occ == 0) check("rd_data_empty", rd_data, 0);
    endtask

    // One clock: drive inputs, apply the spec rules to the model, then check after the edge.
    task automatic cycle(input bit v, input logic [3:0] d, input logic [7:0] p, input bit re,
                         output bit acc);
        bit pop;
        valid   = v;
        item_in = {p, d};
        rd_en   = re;
        acc = v && (occ < DEPTH);
        pop = re && (occ > 0);
        if (acc) begin
            if (d == ID) begin
                exp_q.push_back(p);
                occ++;
                if (rx_m < 65535) rx_m++;
                if (rx_m == MSG) done_m = 1'b1;
            end else if (mis_m < 65535) begin
                mis_m++;
            end
        end
        if (pop) occ--;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit re, input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 8'd0, re, acc);
    endtask

    task automatic send(input logic [3:0] d, input logic [7:0] p, input bit re);
        bit acc = 1'b0;
        for (int k = 0; k < 16 && !acc; k++) cycle(1'b1, d, p, re, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: flit %0h never accepted", p);
        end
    endtask

    // Asynchronous assertion between edges; outputs must clear with no clock edge.
    task automatic do_reset();
        valid   = 1'b0;
        rd_en   = 1'b0;
        item_in = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_misroute", misroute_count, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        exp_q.delete();
        occ    = 0;
        rx_m   = 0;
        mis_m  = 0;
        done_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pop handshake must present the oldest expected payload.
    always @(negedge clk) begin
        if (reset && rd_valid && rd_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h, expected no data", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       acc;
        bit       hv;
        bit [3:0] hd;
        bit [7:0] hp;
        reset   = 1'b0;
        valid   = 1'b0;
        rd_en   = 1'b0;
        item_in = '0;
        do_reset();

        // Basic receive with the consumer always ready.
        for (int i = 0; i < 12; i++) send(4'd3, 8'(8'h41 + i), 1'b1);
        check("basic_rx_count", rx_count, 12);
        check("basic_done", done, 1);
        idle(1'b1, 3);

        // Backpressure: fill, hold flit 5, one pop, then flit 5 goes in.
        do_reset();
        for (int i = 0; i < 4; i++) send(4'd3, 8'(8'h41 + i), 1'b0);
        check("bp_busy_full", busy, 1);
        cycle(1'b1, 4'd3, 8'h45, 1'b0, acc);
        check("bp_busy_held", busy, 1);
        cycle(1'b1, 4'd3, 8'h45, 1'b1, acc);
        check("bp_busy_fall", busy, 0);
        cycle(1'b1, 4'd3, 8'h45, 1'b0, acc);
        check("bp_busy_refill", busy, 1);
        send(4'd3, 8'h46, 1'b1);
        idle(1'b1, 6);

        // Misroute interleaved with matching flits.
        do_reset();
        send(4'd3, 8'h51, 1'b1);
        send(4'd5, 8'h52, 1'b1);
        send(4'd3, 8'h53, 1'b1);
        send(4'd0, 8'h54, 1'b1);
        send(4'd3, 8'h55, 1'b1);
        idle(1'b1, 3);
        check("mis_total", misroute_count, 2);
        check("mis_rx", rx_count, 3);

        // Underflow: rd_en on empty, then the FIFO still delivers correctly.
        idle(1'b1, 3);
        check("uf_rd_valid", rd_valid, 0);
        send(4'd3, 8'h77, 1'b0);
        check("uf_head", rd_data, 8'h77);
        idle(1'b1, 2);

        // Concurrent push and pop at occupancy 2.
        send(4'd3, 8'h10, 1'b0);
        send(4'd3, 8'h11, 1'b0);
        send(4'd3, 8'h12, 1'b1);
        check("cc_head", rd_data, 8'h11);
        idle(1'b1, 4);

        // Wrap: streaming push/pop around the pointers, then full and empty again.
        for (int i = 0; i < 10; i++) send(4'd3, 8'(8'h80 + i), 1'b1);
        idle(1'b1, 2);
        for (int i = 0; i < 4; i++) send(4'd3, 8'(8'h90 + i), 1'b0);
        check("wrap_full", busy, 1);
        idle(1'b1, 5);
        check("wrap_empty", rd_valid, 0);

        // Randomized traffic with upstream hold while busy.
        hv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 9) < 7);
                hd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
                hp = 8'($urandom);
            end
            cycle(hv, hd, hp, ($urandom_range(0, 1) == 1), acc);
            if (acc) hv = 1'b0;
        end
        idle(1'b1, 6);

        // Reset mid-operation with occupancy 3 and rx_count 7.
        do_reset();
        for (int i = 0; i < 4; i++) send(4'd3, 8'(8'hA0 + i), 1'b0);
        idle(1'b1, 4);
        for (int i = 0; i < 3; i++) send(4'd3, 8'(8'hB0 + i), 1'b0);
        check("pre_rst_rx", rx_count, 7);
        check("pre_rst_valid", rd_valid, 1);
        do_reset();
        idle(1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/par_sink_to_memory.md
# par_sink_to_memory

Network-side traffic sink and the receiving end of the parallel source interface. It accepts flits (`{payload, dest}`) presented with `valid`, checks that the destination field equals its own node `id`, and queues matching payloads in a small FIFO that a local consumer drains. It applies backpressure through `busy`, counts received and misrouted flits, and flags completion when a full message has arrived. One instance sits at each network ejection port, opposite a `par_source_from_memory`.

## Interface
- `id`, default -1: node address; compared against the flit's `ADDR_BITS` field.
- `depth`, default 4: FIFO entries, power of two, ≥2.
- `msg_size`, default 12: accepted flits that constitute one complete message.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `item_in`  in  `PAYLOAD_SIZE`+`ADDR_BITS`  flit; `[ADDR_BITS-1:0]` is dest, upper bits are payload.
- `valid`  in  1  `item_in` is meaningful this cycle.
- `busy`  out  1  sink cannot consume; upstream must hold the flit.
- `rd_en`  in  1  consumer pops the FIFO head.
- `rd_data`  out  `PAYLOAD_SIZE`  FIFO head payload (show-ahead).
- `rd_valid`  out  1  FIFO non-empty.
- `rx_count`  out  16  matching flits accepted since reset.
- `misroute_count`  out  16  flits consumed whose dest ≠ `id`.
- `done`  out  1  sticky; `rx_count` has reached `msg_size`.

## Operation
- Consume event: `valid & !busy` at a rising edge.
  - dest == `id`: push payload, `rx_count`+1.
  - dest ≠ `id`: drop the payload, `misroute_count`+1, no push.
- `valid & busy`: no state change. The flit is not consumed and the upstream re-presents it.
- `busy` = FIFO full (occupancy == `depth`), decoded combinationally from registered occupancy.
  - A pop in the same cycle does not lower `busy`.
  - A misrouted flit is also refused while full. This is deliberate and keeps `busy` independent of `item_in`.
- Pop: `rd_en & rd_valid` advances the read pointer. `rd_en` while empty is ignored (no underflow, pointers unchanged).
- Simultaneous push and pop (not full, not empty): both occur; occupancy unchanged.
- Pointers: `log2(depth)` bits plus one wrap bit. Full = low bits equal and wrap bits differ. Empty = pointers equal. Wrap at `depth` is seamless.
- Counters saturate at 16'hFFFF and do not wrap.
- Control FSM, two states:
  - RUN: initial state. Go to DONE when an accept brings `rx_count` to `msg_size`.
  - DONE: `done`=1. Flits are still accepted, stored and counted. Only reset leaves DONE.
- On each accept, print `##,rx,<id>,<payload>` via `$display` when `id` != -1. This is simulation only.

## Timing
- Reset values (async assert, sync release): pointers 0, `rd_valid`=0, `busy`=0, `rd_data`=0, counters 0, `done`=0, FSM=RUN.
- Reset asserted mid-operation clears the FIFO contents, counters and `done` immediately.
- Push latency: a payload accepted at edge N is on `rd_data` with `rd_valid`=1 after edge N. There is no same-cycle bypass from `item_in` to `rd_data`.
- `busy` rises after the edge that fills the last entry. It falls after the first pop edge from the full state.
- `done` rises after the edge of the `msg_size`-th matching accept.

## Structure
- Shared defines header (already in use): `PAYLOAD_SIZE`, `ADDR_BITS`, `NUM_NODES`.
- Add `RX_CNT_BITS`=16 to the same header.
- Sub-module `sink_fifo #(width, depth)` holds the storage, pointers, full/empty and show-ahead read.
- The top level holds the address check, counters and FSM.

## Test plan
Parameters: `id`=3, `depth`=4, `msg_size`=12, `ADDR_BITS`=4, `PAYLOAD_SIZE`=8.
- Basic receive: 12 flits dest=3, payloads 0x41..0x4C, `rd_en`=1 continuously → `rd_data` sequence 0x41..0x4C in order; `rx_count`=12; `done`=1 after the 12th accept edge; `busy` never high.
- Backpressure: `rd_en`=0, 6 flits dest=3 held by the upstream while busy → `busy`=1 after the 4th accept; flits 5–6 not consumed; one pop → `busy`=0 next cycle, flit 5 accepted; contents 0x41..0x45 in order.
- Misroute: flits dest=5 and dest=0 interleaved with dest=3 → `misroute_count`=2; only dest=3 payloads appear on `rd_data`; `rx_count` counts only dest=3 flits.
- Concurrency and underflow: occupancy 2, push and pop in the same cycle → occupancy stays 2, order preserved; `rd_en` on empty for 3 cycles → pointers unchanged, `rd_valid`=0.
- Wrap: 10 push/pop cycles through `depth`=4 → no data loss; full/empty correct across pointer wrap.
- Reset mid-operation: drive `reset`=0 between edges with occupancy 3 and `rx_count`=7 → `rd_valid`, `busy`, counters and `done` go to 0 immediately, without waiting for a clock edge.
